mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the byte-addressed, big-endian 32-bit data RAM in the multi-cycle CPU.
- Accepts one load/store request from the control unit and sequences the RAM's RD/WR/state pins.
- Performs byte and halfword extraction with sign or zero extension.
- RAM writes only whole words, so sub-word stores are done as read-modify-write.

Parameters:
MEM_BYTES, 61, RAM size in bytes; highest legal byte address is MEM_BYTES-1
WR_STATE, 3'b100, value driven on mem_state during a write cycle (RAM commits only in this state)

Ports:
clk  in  1  system clock; all registers update on posedge
rst_n  in  1  asynchronous, active-low reset
req  in  1  request strobe; sampled only when ready=1
we  in  1  1=store, 0=load
op  in  3  size: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (store uses 000/001/010)
addr  in  32  byte address
wdata  in  32  store data, right-aligned
ready  out  1  1 in IDLE only
done  out  1  one-cycle completion pulse
err  out  1  valid with done; misaligned or out-of-range, no memory access made
rdata  out  32  load result; held until next completed load
mem_addr  out  32  word-aligned RAM address
mem_wdata  out  32  RAM write data
mem_RD  out  1  RAM read enable
mem_WR  out  1  RAM write enable
mem_state  out  3  WR_STATE during write cycle, else 3'b000
mem_Dataout  in  32  RAM read data (combinational, valid same cycle as mem_RD)

Behaviour:
- Reset (async): state IDLE.
  - ready=1; done=0; err=0; rdata=0.
  - mem_RD=0; mem_WR=0; mem_state=000; mem_addr=0; mem_wdata=0.
- Outputs are registered; a reset asserted mid-operation drops mem_WR/mem_RD immediately and aborts the access.
- States:
  - IDLE: on req, latch we/op/addr/wdata. Next state is:
    - ERR if misaligned (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0) or out of range (aligned word base+3 > MEM_BYTES-1).
    - WR for sw.
    - RD otherwise.
  - RD: mem_RD=1, mem_addr={addr[31:2],2'b00}.
    - At posedge, capture mem_Dataout into the internal word register.
    - Next state: DONE for loads, WR for sb/sh.
  - WR: mem_WR=1, mem_state=WR_STATE, mem_wdata = full word (sw) or merged word (sb/sh). RAM commits on the negedge inside this cycle. Next state: DONE.
  - DONE: done=1 for one cycle, loads update rdata. Next state: IDLE.
  - ERR: done=1, err=1 for one cycle; rdata unchanged. Next state: IDLE.
- Latency from accepting posedge to done high:
  - lw/lb/lh: 2 cycles.
  - sw: 2 cycles.
  - sb/sh: 3 cycles.
  - error: 1 cycle.
- Lanes are big-endian: byte offset k occupies bits [31-8k:24-8k]; halfword offset 0 is [31:16], offset 2 is [15:0].
- Loads: lb/lh sign-extend, lbu/lhu zero-extend. Stores use wdata[7:0] or wdata[15:0].
- mem_RD and mem_WR are never both 1.
- req while ready=0 is ignored, not queued.
- Undefined op codes (011, 11x) take the ERR path.

Optional Feature:
- Macro: MEM_ACCESS_BOUNDS_EN.
- Defined: the out-of-range check against MEM_BYTES is active, and an out-of-range access goes to ERR.
- Undefined: only alignment is checked; the address passes through unbounded; MEM_BYTES is unused.

Decomposition:
- Shared package holds:
  - op encodings (OP_LB..OP_LHU)
  - FSM state encodings (IDLE, RD, WR, DONE, ERR)
  - MEM_WR_STATE=3'b100
- One natural sub-module: mem_lane_align. It is purely combinational and does two jobs:
  - load extract/extend from word+offset+op
  - store merge of old word+wdata+offset+op

Test Plan:
- RAM word@8=0x11223344; lw 8 -> done 2 cycles after accept, rdata=0x11223344, err=0.
- Word@12=0x80FF7F01:
  - lb 12 -> 0xFFFFFF80
  - lbu 13 -> 0x000000FF
  - lh 14 -> 0x00007F01
  - lhu 12 -> 0x000080FF
- sb addr 10 wdata 0x000000AB over 0x11223344:
  - one RD cycle, then one WR cycle with mem_state=100 and mem_wdata=0x1122AB44
  - done 3 cycles after accept
  - lw 8 then returns 0x1122AB44
- Misalignment:
  - lw 6 -> done+err 1 cycle after accept, mem_RD/mem_WR never asserted
  - sh 5 -> same response
- With MEM_ACCESS_BOUNDS_EN and MEM_BYTES=61:
  - lw 60 -> err
  - lw 56 -> succeeds
- sw 0 wdata 0xDEADBEEF with rst_n pulled low before the WR-cycle negedge -> mem_WR drops at once, RAM word@0 unchanged, outputs return to reset values.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-RAM initiator: access op codes, FSM states and
// the RAM write-state value.
package mem_access_unit_pkg;

  localparam int         DATA_W       = 32;
  localparam logic [2:0] MEM_WR_STATE = 3'b100;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  // Stores only have the three sized forms; the unsigned variants are load-only.
  function automatic logic op_legal(input logic we, input logic [2:0] op);
    logic ok;
    ok = (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
    if (!we) ok = ok || (op == OP_LBU) || (op == OP_LHU);
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake from the control unit plus the RAM pin bundle.
// slave = the access unit, master = control unit and RAM together.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_RD;
  logic        mem_WR;
  logic [2:0]  mem_state;
  logic [31:0] mem_Dataout;

  modport slave (
    input  req, we, op, addr, wdata, mem_Dataout,
    output ready, done, err, rdata, mem_addr, mem_wdata, mem_RD, mem_WR, mem_state
  );

  modport master (
    output req, we, op, addr, wdata, mem_Dataout,
    input  ready, done, err, rdata, mem_addr, mem_wdata, mem_RD, mem_WR, mem_state
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Big-endian lane steering: sub-word load extract/extend and sub-word store
// merge into the old RAM word. Purely combinational.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  op,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  function automatic logic [31:0] ext8(input logic [7:0] v, input logic sgn);
    logic signed [7:0]  s;
    logic signed [31:0] w;
    s = signed'(v);
    w = s;
    return sgn ? 32'(w) : {24'd0, v};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
    logic signed [15:0] s;
    logic signed [31:0] w;
    s = signed'(v);
    w = s;
    return sgn ? 32'(w) : {16'd0, v};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'd0;
    case (offset)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase
    half_sel = offset[1] ? word[15:0] : word[31:16];

    load_data = 32'd0;
    case (op)
      OP_LB:   load_data = ext8(byte_sel, 1'b1);
      OP_LBU:  load_data = ext8(byte_sel, 1'b0);
      OP_LH:   load_data = ext16(half_sel, 1'b1);
      OP_LHU:  load_data = ext16(half_sel, 1'b0);
      OP_LW:   load_data = word;
      default: load_data = 32'd0;
    endcase
  end

  // Word stores never pass through here; they bypass the read phase.
  always_comb begin
    store_word = word;
    case (op[1:0])
      2'b00: begin
        case (offset)
          2'd0:    store_word[31:24] = wdata[7:0];
          2'd1:    store_word[23:16] = wdata[7:0];
          2'd2:    store_word[15:8]  = wdata[7:0];
          default: store_word[7:0]   = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (offset[1]) store_word[15:0]  = wdata;
        else           store_word[31:16] = wdata;
      end
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer for the big-endian word RAM; sub-word stores are done
// as read-modify-write. Define MEM_ACCESS_BOUNDS_EN to reject accesses past MEM_BYTES.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int         MEM_BYTES = 61,
  parameter logic [2:0] WR_STATE  = MEM_WR_STATE
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave bus
);

`ifdef MEM_ACCESS_BOUNDS_EN
  localparam bit BOUNDS_ON = 1'b1;
`else
  localparam bit BOUNDS_ON = 1'b0;
`endif

  state_e      state;
  logic        ready_q, done_q, err_q;
  logic [31:0] rdata_q, mem_addr_q, mem_wdata_q;
  logic        mem_rd_q, mem_wr_q;
  logic [2:0]  mem_state_q;
  logic        we_q;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;

  logic        misalign, out_of_range, reject;
  logic [31:0] load_data, store_word;

  // The last byte of the containing word must fit, so even a byte access
  // near the top is rejected when its word straddles MEM_BYTES.
  always_comb begin
    misalign     = ((bus.op[1:0] == 2'b01) && bus.addr[0]) ||
                   ((bus.op[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    out_of_range = {1'b0, bus.addr[31:2], 2'b11} > 33'(MEM_BYTES - 1);
    reject       = !op_legal(bus.we, bus.op) || misalign || (BOUNDS_ON && out_of_range);
  end

  mem_lane_align u_lane (
    .word       (bus.mem_Dataout),
    .offset     (off_q),
    .op         (op_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_state_q <= 3'b000;
      we_q        <= 1'b0;
      op_q        <= 3'b000;
      off_q       <= 2'b00;
      wdata_q     <= 16'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            op_q    <= bus.op;
            off_q   <= bus.addr[1:0];
            wdata_q <= bus.wdata[15:0];
            ready_q <= 1'b0;
            if (reject) begin
              state  <= ERR;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (bus.we && (bus.op == OP_LW)) begin
              state       <= WR;
              mem_addr_q  <= {bus.addr[31:2], 2'b00};
              mem_wdata_q <= bus.wdata;
              mem_wr_q    <= 1'b1;
              mem_state_q <= WR_STATE;
            end else begin
              state      <= RD;
              mem_addr_q <= {bus.addr[31:2], 2'b00};
              mem_rd_q   <= 1'b1;
            end
          end
        end
        // Read data is only valid while mem_RD is up, so extract or merge now.
        RD: begin
          mem_rd_q <= 1'b0;
          if (we_q) begin
            state       <= WR;
            mem_wdata_q <= store_word;
            mem_wr_q    <= 1'b1;
            mem_state_q <= WR_STATE;
          end else begin
            state   <= DONE;
            done_q  <= 1'b1;
            rdata_q <= load_data;
          end
        end
        WR: begin
          state       <= DONE;
          mem_wr_q    <= 1'b0;
          mem_state_q <= 3'b000;
          done_q      <= 1'b1;
        end
        DONE, ERR: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          ready_q     <= 1'b1;
          mem_rd_q    <= 1'b0;
          mem_wr_q    <= 1'b0;
          mem_state_q <= 3'b000;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_RD    = mem_rd_q;
  assign bus.mem_WR    = mem_wr_q;
  assign bus.mem_state = mem_state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: fixed vector table, hand sequences for bounds and
// mid-write reset, then random traffic against a byte-array reference model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int MEM_BYTES = 61;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(.MEM_BYTES(MEM_BYTES), .WR_STATE(3'b100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RAM: combinational read, write committed on the negedge in write state.
  logic [31:0] ram [16];
  assign bus.mem_Dataout = ram[bus.mem_addr[5:2]];
  always @(negedge clk)
    if (bus.mem_WR && bus.mem_state == 3'b100) ram[bus.mem_addr[5:2]] <= bus.mem_wdata;

  // Reference model: plain byte array, big-endian.
  logic [7:0]  mb [64];
  logic [31:0] model_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] w);
    ram[idx]       = w;
    mb[4*idx + 0]  = w[31:24];
    mb[4*idx + 1]  = w[23:16];
    mb[4*idx + 2]  = w[15:8];
    mb[4*idx + 3]  = w[7:0];
  endtask

  task automatic model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic e, output int lat,
                       output int rdc, output int wrc, output logic [31:0] wword);
    int          size;
    int          base;
    logic [31:0] v;
    size  = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    e     = !(we ? (op inside {3'b000, 3'b001, 3'b010})
                 : (op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}));
    if (addr % size != 0) e = 1'b1;
`ifdef MEM_ACCESS_BOUNDS_EN
    if ((addr / 4) * 4 + 3 > MEM_BYTES - 1) e = 1'b1;
`endif
    wword = 32'd0;
    if (e) begin
      lat = 1; rdc = 0; wrc = 0;
    end else if (!we) begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = (v << 8) | 32'(mb[int'(addr) + i]);
      if (!op[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      model_rdata = v;
      lat = 2; rdc = 1; wrc = 0;
    end else begin
      for (int i = 0; i < size; i++) mb[int'(addr) + i] = 8'(wdata >> (8*(size-1-i)));
      base  = int'(addr) & ~3;
      wword = {mb[base], mb[base+1], mb[base+2], mb[base+3]};
      lat   = (size == 4) ? 2 : 3;
      rdc   = (size == 4) ? 0 : 1;
      wrc   = 1;
    end
  endtask

  task automatic run_txn(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag,
                         input logic exp_err, input logic [31:0] exp_rd, input int exp_lat,
                         input int exp_rdc, input int exp_wrc, input logic [31:0] exp_wd);
    int          waitc, cyc, rdc, wrc, both;
    logic        got_done, gerr;
    logic [31:0] grd, wd;
    logic [2:0]  wst;
    waitc = 0; cyc = 0; rdc = 0; wrc = 0; both = 0;
    got_done = 1'b0; gerr = 1'b0; grd = 32'd0; wd = 32'd0; wst = 3'd0;
    @(negedge clk);
    while (!bus.ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
    if (!bus.ready) return;
    bus.req = 1'b1; bus.we = we; bus.op = op; bus.addr = addr; bus.wdata = wdata;
    while (!got_done && cyc < 8) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) bus.req = 1'b0;
      if (bus.mem_RD) rdc++;
      if (bus.mem_WR) begin
        wrc++;
        wst = bus.mem_state;
        wd  = bus.mem_wdata;
      end
      if (bus.mem_RD && bus.mem_WR) both++;
      if (bus.done) begin
        got_done = 1'b1;
        gerr     = bus.err;
        grd      = bus.rdata;
      end
    end
    chk({tag, "_lat"},   32'(cyc),  32'(exp_lat));
    chk({tag, "_err"},   32'(gerr), 32'(exp_err));
    chk({tag, "_rdata"}, grd,       exp_rd);
    chk({tag, "_rdcyc"}, 32'(rdc),  32'(exp_rdc));
    chk({tag, "_wrcyc"}, 32'(wrc),  32'(exp_wrc));
    chk({tag, "_rdwr"},  32'(both), 32'd0);
    if (exp_wrc > 0) begin
      chk({tag, "_wrstate"}, 32'(wst), 32'h4);
      chk({tag, "_wdata"},   wd,       exp_wd);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"},     32'(bus.ready),     32'd1);
    chk({tag, "_done"},      32'(bus.done),      32'd0);
    chk({tag, "_err"},       32'(bus.err),       32'd0);
    chk({tag, "_rdata"},     bus.rdata,          32'd0);
    chk({tag, "_mem_RD"},    32'(bus.mem_RD),    32'd0);
    chk({tag, "_mem_WR"},    32'(bus.mem_WR),    32'd0);
    chk({tag, "_mem_state"}, 32'(bus.mem_state), 32'd0);
    chk({tag, "_mem_addr"},  bus.mem_addr,       32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic        m_err, r_we;
  logic [2:0]  r_op;
  logic [31:0] m_wd, r_addr, r_wdata;
  int          m_lat, m_rdc, m_wrc;

  initial begin
    vt[0]  = '{1'b0, 3'b010, 32'd8,  32'h0,        1'b0, 32'h1122_3344, 2, 32'h0};
    vt[1]  = '{1'b0, 3'b000, 32'd12, 32'h0,        1'b0, 32'hFFFF_FF80, 2, 32'h0};
    vt[2]  = '{1'b0, 3'b100, 32'd13, 32'h0,        1'b0, 32'h0000_00FF, 2, 32'h0};
    vt[3]  = '{1'b0, 3'b001, 32'd14, 32'h0,        1'b0, 32'h0000_7F01, 2, 32'h0};
    vt[4]  = '{1'b0, 3'b101, 32'd12, 32'h0,        1'b0, 32'h0000_80FF, 2, 32'h0};
    vt[5]  = '{1'b0, 3'b010, 32'd6,  32'h0,        1'b1, 32'h0000_80FF, 1, 32'h0};
    vt[6]  = '{1'b1, 3'b001, 32'd5,  32'h0000_5555, 1'b1, 32'h0000_80FF, 1, 32'h0};
    vt[7]  = '{1'b1, 3'b000, 32'd10, 32'h0000_00AB, 1'b0, 32'h0000_80FF, 3, 32'h1122_AB44};
    vt[8]  = '{1'b0, 3'b010, 32'd8,  32'h0,        1'b0, 32'h1122_AB44, 2, 32'h0};
    vt[9]  = '{1'b0, 3'b011, 32'd0,  32'h0,        1'b1, 32'h1122_AB44, 1, 32'h0};
    vt[10] = '{1'b1, 3'b010, 32'd16, 32'hCAFE_F00D, 1'b0, 32'h1122_AB44, 2, 32'hCAFE_F00D};
    vt[11] = '{1'b0, 3'b101, 32'd18, 32'h0,        1'b0, 32'h0000_F00D, 2, 32'h0};
    vt[12] = '{1'b1, 3'b001, 32'd14, 32'hFFFF_1234, 1'b0, 32'h0000_F00D, 3, 32'h80FF_1234};
    vt[13] = '{1'b0, 3'b000, 32'd15, 32'h0,        1'b0, 32'h0000_0034, 2, 32'h0};

    bus.req = 1'b0; bus.we = 1'b0; bus.op = 3'b000; bus.addr = 32'd0; bus.wdata = 32'd0;
    for (int i = 0; i < 16; i++) preload(i, 32'd0);
    preload(2,  32'h1122_3344);
    preload(3,  32'h80FF_7F01);
    preload(14, 32'h5A5A_0001);
    preload(15, 32'h0F0F_0F0F);
    model_rdata = 32'd0;

    rst_n = 1'b0;
    #12;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      model(vt[i].we, vt[i].op, vt[i].addr, vt[i].wdata, m_err, m_lat, m_rdc, m_wrc, m_wd);
      run_txn(vt[i].we, vt[i].op, vt[i].addr, vt[i].wdata, $sformatf("vec%0d", i),
              vt[i].exp_err, vt[i].exp_rdata, vt[i].exp_lat, m_rdc, m_wrc, vt[i].exp_wd);
    end

`ifdef MEM_ACCESS_BOUNDS_EN
    model(1'b0, 3'b010, 32'd60, 32'd0, m_err, m_lat, m_rdc, m_wrc, m_wd);
    run_txn(1'b0, 3'b010, 32'd60, 32'd0, "bound60", 1'b1, 32'h0000_0034, 1, 0, 0, 32'd0);
`else
    model(1'b0, 3'b010, 32'd60, 32'd0, m_err, m_lat, m_rdc, m_wrc, m_wd);
    run_txn(1'b0, 3'b010, 32'd60, 32'd0, "nobound60", 1'b0, 32'h0F0F_0F0F, 2, 1, 0, 32'd0);
`endif
    model(1'b0, 3'b010, 32'd56, 32'd0, m_err, m_lat, m_rdc, m_wrc, m_wd);
    run_txn(1'b0, 3'b010, 32'd56, 32'd0, "bound56", 1'b0, 32'h5A5A_0001, 2, 1, 0, 32'd0);

    // sw aborted by reset between accept and the committing negedge
    preload(0, 32'h0102_0304);
    @(negedge clk);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.op = 3'b010; bus.addr = 32'd0; bus.wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    chk("midrst_wr_before", 32'(bus.mem_WR), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    @(negedge clk);
    chk("midrst_ram0", ram[0], 32'h0102_0304);
    rst_n = 1'b1;
    model_rdata = 32'd0;

    for (int n = 0; n < 200; n++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_op    = 3'($urandom_range(0, 7));
      r_addr  = 32'($urandom_range(0, 63));
      r_wdata = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (r_op[1:0] == 2'b10)      r_addr = r_addr & ~32'd3;
        else if (r_op[1:0] == 2'b01) r_addr = r_addr & ~32'd1;
      end
      model(r_we, r_op, r_addr, r_wdata, m_err, m_lat, m_rdc, m_wrc, m_wd);
      run_txn(r_we, r_op, r_addr, r_wdata, $sformatf("rnd%0d", n),
              m_err, model_rdata, m_lat, m_rdc, m_wrc, m_wd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
